// File: rtl/bcd_disp_pkg.sv
// Shared constants for the mm:ss seven-segment display path.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] IDX_MIN_TENS = 2'd3;
  localparam logic [1:0] IDX_MIN_ONES = 2'd2;
  localparam logic [1:0] IDX_SEC_TENS = 2'd1;
  localparam logic [1:0] IDX_SEC_ONES = 2'd0;

  // Tens digits of mm:ss only ever reach 5.
  function automatic logic digit_invalid(input logic [3:0] value, input logic is_tens);
    return (value > 4'd9) || (is_tens && (value > 4'd5));
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD digit to seven-segment decoder; out-of-range digits show a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] value,
  input  logic       is_tens,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (!digit_invalid(value, is_tens)) begin
      case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_time_display.sv
// Multiplexed 4-digit mm:ss display driver with per-frame digit snapshot,
// leading-zero blanking, blinking colon and sticky invalid-digit flag.
module bcd_time_display
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic       blank_lz,
  input  logic       colon_en,
  output logic [6:0] seg,
  output logic [3:0] digit_en,
  output logic       colon,
  output logic       frame_done,
  output logic       err
);

  localparam int unsigned PW = $clog2(SCAN_DIV + 1);
  localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

  logic [PW-1:0]   presc;
  logic [1:0]      idx;
  logic [FW-1:0]   frame_cnt;
  logic            phase;
  logic [3:0][3:0] shadow;

  logic       tick;
  logic       snap;
  logic       frame_wrap;
  logic       cur_is_tens;
  logic       blank_now;
  logic       snap_bad;
  logic [6:0] dec_seg;

  assign tick        = (presc == PW'(SCAN_DIV - 1));
  assign snap        = tick && (idx == IDX_SEC_ONES);
  assign frame_wrap  = (frame_cnt == FW'(BLINK_FRAMES - 1));
  assign cur_is_tens = (idx == IDX_MIN_TENS) || (idx == IDX_SEC_TENS);
  assign blank_now   = blank_lz && (idx == IDX_MIN_TENS) && (shadow[IDX_MIN_TENS] == 4'd0);
  assign snap_bad    = digit_invalid(shadow[IDX_MIN_TENS], 1'b1) ||
                       digit_invalid(shadow[IDX_MIN_ONES], 1'b0) ||
                       digit_invalid(shadow[IDX_SEC_TENS], 1'b1) ||
                       digit_invalid(shadow[IDX_SEC_ONES], 1'b0);

  bcd_to_7seg u_dec (
    .value   (shadow[idx]),
    .is_tens (cur_is_tens),
    .seg     (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= IDX_MIN_TENS;
      frame_cnt  <= '0;
      phase      <= 1'b0;
      shadow     <= '0;
      seg        <= '0;
      digit_en   <= '0;
      colon      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      // Decrementing a 2-bit index wraps 0 -> 3, which is exactly the frame restart.
      if (tick) idx <= idx - 2'd1;
      if (snap) begin
        shadow    <= {min_tens, min_ones, sec_tens, sec_ones};
        frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
        if (frame_wrap) phase <= ~phase;
      end
      digit_en   <= 4'b0001 << idx;
      seg        <= blank_now ? SEG_BLANK : dec_seg;
      colon      <= phase & colon_en;
      frame_done <= snap;
      // frame_done marks the cycle in which the fresh snapshot sits in shadow.
      if (frame_done && snap_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_time_display.sv
// Directed + randomized check of bcd_time_display against a cycle-count
// reference model (SCAN_DIV=2, BLINK_FRAMES=2).
module tb_bcd_time_display;

  localparam int SD = 2;
  localparam int BF = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] min_tens = 4'd1, min_ones = 4'd2, sec_tens = 4'd3, sec_ones = 4'd4;
  logic       blank_lz = 1'b0;
  logic       colon_en = 1'b1;
  logic [6:0] seg;
  logic [3:0] digit_en;
  logic       colon, frame_done, err;

  int total = 0;
  int bad   = 0;

  // Reference model state: edges since reset release, current displayed
  // snapshot, number of snapshots so far, and sticky error.
  int       n;
  int       m_sh [4];
  int       m_k;
  bit       m_err;
  logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  bcd_time_display #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .min_tens   (min_tens),
    .min_ones   (min_ones),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .blank_lz   (blank_lz),
    .colon_en   (colon_en),
    .seg        (seg),
    .digit_en   (digit_en),
    .colon      (colon),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(int v, bit tens);
    return (v > 9) || (tens && v > 5);
  endfunction

  task automatic model_reset();
    n = 0;
    m_k = 0;
    m_err = 0;
    for (int i = 0; i < 4; i++) m_sh[i] = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".seg"}, seg, 7'h00);
    chk({tag, ".digit_en"}, {3'b0, digit_en}, 7'h00);
    chk({tag, ".colon"}, {6'b0, colon}, 7'h00);
    chk({tag, ".frame_done"}, {6'b0, frame_done}, 7'h00);
    chk({tag, ".err"}, {6'b0, err}, 7'h00);
  endtask

  // One clock edge: inputs currently driven are the values sampled at it.
  task automatic step();
    int d, v;
    bit tens, fd;
    logic [6:0] e_seg;
    logic [3:0] e_en;
    @(posedge clk);
    #1;
    n++;
    d    = 3 - ((n - 1) % FRAME) / SD;
    v    = m_sh[d];
    tens = (d == 3) || (d == 1);
    e_en = 4'b0001 << d;
    if (blank_lz && d == 3 && v == 0) e_seg = 7'h00;
    else if (is_bad(v, tens))         e_seg = 7'h40;
    else                              e_seg = lut[v];
    fd = (n % FRAME) == 0;
    chk("seg", seg, e_seg);
    chk("digit_en", {3'b0, digit_en}, {3'b0, e_en});
    chk("colon", {6'b0, colon}, {6'b0, colon_en && ((m_k / BF) % 2 == 1)});
    chk("frame_done", {6'b0, frame_done}, {6'b0, fd});
    chk("err", {6'b0, err}, {6'b0, m_err});
    if (fd) begin
      m_sh[3] = int'(min_tens);
      m_sh[2] = int'(min_ones);
      m_sh[1] = int'(sec_tens);
      m_sh[0] = int'(sec_ones);
      m_k++;
      if (is_bad(m_sh[3], 1) || is_bad(m_sh[2], 0) || is_bad(m_sh[1], 1) || is_bad(m_sh[0], 0))
        m_err = 1;
    end
  endtask

  task automatic set_time(input int mt, input int mo, input int st, input int so);
    min_tens = 4'(mt);
    min_ones = 4'(mo);
    sec_tens = 4'(st);
    sec_ones = 4'(so);
  endtask

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // 12:34, then a mid-frame change to 56:78
    repeat (20) step();
    set_time(5, 6, 7, 8);
    repeat (20) step();

    // 05:07 with blanking on, off, then toggled randomly
    set_time(0, 5, 0, 7);
    blank_lz = 1'b1;
    repeat (16) step();
    blank_lz = 1'b0;
    repeat (16) step();
    repeat (16) begin
      blank_lz = 1'($urandom_range(0, 1));
      step();
    end
    blank_lz = 1'b0;

    // invalid min_tens, then restore: err stays sticky
    set_time(7, 2, 3, 4);
    repeat (12) step();
    set_time(1, 2, 3, 4);
    repeat (20) step();

    // colon enable toggled
    repeat (32) begin
      colon_en = 1'($urandom_range(0, 1));
      step();
    end
    colon_en = 1'b1;

    // asynchronous reset in the middle of a digit
    repeat (3) step();
    #2 rst = 1'b1;
    #1 check_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (12) step();

    // randomized traffic
    repeat (240) begin
      if ($urandom_range(0, 3) == 0) begin
        min_tens = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
        min_ones = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        sec_tens = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
        sec_ones = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) colon_en = 1'($urandom_range(0, 1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
